hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  ID stage holds a valid decoded instruction.
REQ-004 id_rs1_addr, id_rs2_addr  in  5 each  ID source registers.
REQ-005 id_rd_addr  in  5; id_rd_wren  in  1; id_mem_rden  in  1  ID destination/load flags from decode.
REQ-006 ex_redirect  in  1  EX resolved taken branch or jump this cycle.
REQ-007 mem_req  in  1; mem_ack  in  1  MEM-stage data-memory request/acknowledge.
REQ-008 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
REQ-009 if_id_flush, id_ex_flush  out  1 each  insert bubble into that register.
REQ-010 fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback.
REQ-011 state  out  2  FSM state (debug).
REQ-012 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-013 Block SHALL keep a shadow scoreboard of EX, MEM and WB stages: {valid, rs1, rs2, rd, rd_wren, mem_rden}.
REQ-014 Scoreboard SHALL shift ID->EX->MEM->WB each cycle both id_ex_en and ex_mem_en are 1; flushed or stalled ID entry enters EX as invalid.
REQ-015 Load-use hazard = id_valid & ex.valid & ex.mem_rden & ex.rd_wren & ex.rd!=0 & (ex.rd==id_rs1_addr | ex.rd==id_rs2_addr).
REQ-016 On load-use (state RUN, no redirect): pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1; exactly one bubble cycle per hazard.
REQ-017 On ex_redirect (state RUN): if_id_flush=1, id_ex_flush=1, pc_en=1; redirect SHALL take priority over load-use.
REQ-018 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when mem_req & !mem_ack; MEM_WAIT->RUN on mem_ack.
REQ-019 In MEM_WAIT or while mem_req & !mem_ack, all enables SHALL be 0, no flush asserted, scoreboard frozen; ex_redirect ignored and re-sampled after wait.
REQ-020 mem_req & mem_ack in same cycle SHALL cause no stall.
REQ-021 Forwarding (per operand, x0 never forwarded): mem.valid & mem.rd_wren & !mem.mem_rden & mem.rd==ex.rsN -> 01; else wb.valid & wb.rd_wren & wb.rd==ex.rsN -> 10; else 00; MEM match beats WB.
REQ-022 All enables, flushes, fwd selects SHALL be combinational from state, scoreboard and current inputs (zero latency).
REQ-023 stall_cnt SHALL increment on every cycle pc_en=0; flush_cnt on every cycle if_id_flush=1; both saturate at 16'hFFFF.
REQ-024 No outputs SHALL be X when inputs are known.

Reset
REQ-025 On i_rst_n=0 (asynchronous): scoreboard all invalid, state=RUN, counters 0.
REQ-026 During and after reset with idle inputs: all enables 1, flushes 0, fwd selects 00.
REQ-027 Reset mid-MEM_WAIT SHALL return to RUN without waiting for mem_ack.

Structure
REQ-028 Shared package hazard_pkg SHALL hold state enum, fwd select constants and scoreboard-entry struct.
REQ-029 Scoreboard SHALL be one sub-module hz_scoreboard; FSM, hazard logic and counters stay in hazard_ctrl.

Verification
REQ-030 EX: lw x5 valid; ID: add x6,x5,x1 -> one cycle pc_en=0, id_ex_flush=1; next cycle fwd_a_sel=10; stall_cnt=1.
REQ-031 MEM: add x3 (no load); EX rs2=x3; WB also writes x3 -> fwd_b_sel=01.
REQ-032 ex_redirect=1 with load-use simultaneously -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
REQ-033 mem_req=1, mem_ack low 3 cycles -> state MEM_WAIT, all enables 0 for 3 cycles, RUN on ack, stall_cnt=3.
REQ-034 Producer rd=x0 matching EX rs1=x0 -> fwd_a_sel=00, no load-use stall.
REQ-035 Assert i_rst_n low during MEM_WAIT, counters nonzero -> state RUN, counters 0, enables 1 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] StRun     = 2'b00;
  localparam logic [1:0] StMemWait = 2'b01;

  localparam logic [1:0] FwdRegfile = 2'b00;
  localparam logic [1:0] FwdExMem   = 2'b01;
  localparam logic [1:0] FwdMemWb   = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_wren;
    logic       mem_rden;
  } sb_entry_t;

  localparam sb_entry_t SbEmpty = '0;

  // mem_ok/wb_ok already fold in valid, write-enable and (for MEM) not-a-load.
  function automatic logic [1:0] fwd_sel(input logic       mem_ok,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_ok,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] rs);
    logic [1:0] sel;
    sel = FwdRegfile;
    if (rs != 5'd0) begin
      if (mem_ok && (mem_rd == rs)) begin
        sel = FwdExMem;
      end else if (wb_ok && (wb_rd == rs)) begin
        sel = FwdMemWb;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Shadow copy of the EX, MEM and WB stage contents, advanced with the pipeline.
module hz_scoreboard
  import hazard_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      shift_en_i,
  input  sb_entry_t id_entry_i,
  output sb_entry_t ex_o,
  output sb_entry_t mem_o,
  output sb_entry_t wb_o
);

  sb_entry_t ex_q, mem_q, wb_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= SbEmpty;
      mem_q <= SbEmpty;
      wb_q  <= SbEmpty;
    end else if (shift_en_i) begin
      ex_q  <= id_entry_i;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, memory wait, forwarding selects.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_wren,
  input  logic        id_mem_rden,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [1:0]  state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  sb_entry_t   id_e, ex_e, mem_e, wb_e;
  logic        mem_stall, load_use, shift_en;

  hz_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .shift_en_i (shift_en),
    .id_entry_i (id_e),
    .ex_o       (ex_e),
    .mem_o      (mem_e),
    .wb_o       (wb_e)
  );

  // The ack cycle itself releases the pipeline, so an N-cycle wait costs N stall cycles.
  assign mem_stall = ((state_q == StMemWait) || mem_req) && !mem_ack;

  assign load_use = id_valid && ex_e.valid && ex_e.mem_rden && ex_e.rd_wren &&
                    (ex_e.rd != 5'd0) &&
                    ((ex_e.rd == id_rs1_addr) || (ex_e.rd == id_rs2_addr));

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign shift_en = id_ex_en && ex_mem_en;

  always_comb begin
    id_e          = SbEmpty;
    id_e.valid    = id_valid && !id_ex_flush;
    id_e.rs1      = id_rs1_addr;
    id_e.rs2      = id_rs2_addr;
    id_e.rd       = id_rd_addr;
    id_e.rd_wren  = id_rd_wren;
    id_e.mem_rden = id_mem_rden;
  end

  logic mem_fwd_ok, wb_fwd_ok;
  assign mem_fwd_ok = mem_e.valid && mem_e.rd_wren && !mem_e.mem_rden;
  assign wb_fwd_ok  = wb_e.valid && wb_e.rd_wren;
  assign fwd_a_sel  = fwd_sel(mem_fwd_ok, mem_e.rd, wb_fwd_ok, wb_e.rd, ex_e.rs1);
  assign fwd_b_sel  = fwd_sel(mem_fwd_ok, mem_e.rd, wb_fwd_ok, wb_e.rd, ex_e.rs2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:     if (mem_req && !mem_ack) state_d = StMemWait;
      StMemWait: if (mem_ack) state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (if_id_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  logic unused_fields;
  assign unused_fields = ^{mem_e.rs1, mem_e.rs2, wb_e.rs1, wb_e.rs2, wb_e.mem_rden};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rd_wren, id_mem_rden;
  logic        ex_redirect, mem_req, mem_ack;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel, state;
  logic [15:0] stall_cnt, flush_cnt;

  logic [4:0]  ens;
  logic [1:0]  fls;
  int          n_checks = 0;
  int          n_errors = 0;

  hazard_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rd_addr  (id_rd_addr),
    .id_rd_wren  (id_rd_wren),
    .id_mem_rden (id_mem_rden),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .id_ex_en    (id_ex_en),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  assign ens = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  assign fls = {if_id_flush, id_ex_flush};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wren, input logic rden);
    id_valid    = v;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_rd_addr  = rd;
    id_rd_wren  = wren;
    id_mem_rden = rden;
  endtask

  task automatic idle_inputs;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex_redirect = 1'b0;
    mem_req     = 1'b0;
    mem_ack     = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    idle_inputs();
    i_rst_n = 1'b0;
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle_inputs();
    #12;
    check_eq("rst_ens", ens, 5'h1F);
    check_eq("rst_flush", fls, 2'b00);
    check_eq("rst_fwd", {fwd_a_sel, fwd_b_sel}, 4'h0);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_cnts", {stall_cnt, flush_cnt}, 32'h0);
    i_rst_n = 1'b1;
    next_cycle();

    // Load-use: lw x5 then add x6,x5,x1
    drive_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    #2 check_eq("lu_first_ens", ens, 5'h1F);
    next_cycle();
    drive_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    #2 check_eq("lu_stall_ens", ens, 5'b00111);
    check_eq("lu_stall_flush", fls, 2'b01);
    next_cycle();
    #2 check_eq("lu_release_ens", ens, 5'h1F);
    check_eq("lu_stall_cnt", stall_cnt, 16'd1);
    next_cycle();
    idle_inputs();
    #2 check_eq("lu_fwd_a", fwd_a_sel, 2'b10);
    check_eq("lu_fwd_b", fwd_b_sel, 2'b00);
    check_eq("lu_stall_cnt2", stall_cnt, 16'd1);

    // MEM beats WB for x3 on operand b
    do_reset();
    next_cycle();
    drive_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    next_cycle();
    drive_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    next_cycle();
    drive_id(1'b1, 5'd4, 5'd3, 5'd7, 1'b1, 1'b0);
    #2 check_eq("fwd_no_stall", ens, 5'h1F);
    next_cycle();
    idle_inputs();
    #2 check_eq("fwd_b_mem", fwd_b_sel, 2'b01);
    check_eq("fwd_a_none", fwd_a_sel, 2'b00);
    check_eq("fwd_stall_cnt", stall_cnt, 16'd0);

    // Redirect wins over load-use
    do_reset();
    next_cycle();
    drive_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    next_cycle();
    drive_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #2 check_eq("redir_flush", fls, 2'b11);
    check_eq("redir_ens", ens, 5'h1F);
    next_cycle();
    idle_inputs();
    #2 check_eq("redir_flush_cnt", flush_cnt, 16'd1);
    check_eq("redir_stall_cnt", stall_cnt, 16'd0);
    check_eq("redir_after_ens", ens, 5'h1F);

    // Memory wait of three cycles, redirect ignored while waiting
    do_reset();
    next_cycle();
    mem_req = 1'b1;
    #2 check_eq("mw_c1_state", state, 2'd0);
    check_eq("mw_c1_ens", ens, 5'h00);
    check_eq("mw_c1_flush", fls, 2'b00);
    next_cycle();
    ex_redirect = 1'b1;
    #2 check_eq("mw_c2_state", state, 2'd1);
    check_eq("mw_c2_ens", ens, 5'h00);
    check_eq("mw_c2_flush", fls, 2'b00);
    next_cycle();
    ex_redirect = 1'b0;
    #2 check_eq("mw_c3_ens", ens, 5'h00);
    next_cycle();
    mem_ack = 1'b1;
    #2 check_eq("mw_ack_state", state, 2'd1);
    check_eq("mw_ack_ens", ens, 5'h1F);
    check_eq("mw_ack_stall_cnt", stall_cnt, 16'd3);
    next_cycle();
    idle_inputs();
    #2 check_eq("mw_run_state", state, 2'd0);
    check_eq("mw_run_stall_cnt", stall_cnt, 16'd3);
    check_eq("mw_run_flush_cnt", flush_cnt, 16'd0);

    // x0 never forwarded and never causes load-use
    do_reset();
    next_cycle();
    drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    next_cycle();
    drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    #2 check_eq("x0_no_lu", ens, 5'h1F);
    next_cycle();
    drive_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    #2 check_eq("x0_no_lu2", ens, 5'h1F);
    next_cycle();
    idle_inputs();
    #2 check_eq("x0_fwd", {fwd_a_sel, fwd_b_sel}, 4'h0);
    check_eq("x0_stall_cnt", stall_cnt, 16'd0);

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    next_cycle();
    ex_redirect = 1'b1;
    next_cycle();
    ex_redirect = 1'b0;
    mem_req = 1'b1;
    next_cycle();
    #1 check_eq("rmw_state", state, 2'd1);
    check_eq("rmw_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd1});
    i_rst_n = 1'b0;
    mem_req = 1'b0;
    #1 check_eq("rmw_rst_state", state, 2'd0);
    check_eq("rmw_rst_cnts", {stall_cnt, flush_cnt}, 32'h0);
    check_eq("rmw_rst_ens", ens, 5'h1F);
    i_rst_n = 1'b1;
    next_cycle();

    // Stall counter saturation
    mem_req = 1'b1;
    repeat (65540) @(posedge i_clk);
    #1 check_eq("sat_stall_cnt", stall_cnt, 16'hFFFF);
    check_eq("sat_state", state, 2'd1);
    idle_inputs();
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    #2 check_eq("sat_hold", stall_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
